// File: rtl/timebase_gen.sv
// Half-second timebase with an hours/minutes/seconds clock, saturating elapsed-time
// accumulators, run/pause, clear, validated preload and wrap-or-hold rollover.
module timebase_gen #(
    parameter int DIV      = 1024,
    parameter int HRS_W    = 7,
    parameter int HRS_MAX  = 99,
    parameter int ACC_W    = 13,
    parameter int SAT_MODE = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    input  logic               clear,
    input  logic               load_en,
    input  logic [HRS_W+11:0]  load_hms,
    output logic [HRS_W+11:0]  HMS_time,
    output logic [ACC_W-1:0]   sec_accum,
    output logic [ACC_W-1:0]   min_accum,
    output logic               half_sec_pulse,
    output logic               sec_pulse,
    output logic               min_pulse,
    output logic               overflow,
    output logic               load_err
);

    localparam int DW = $clog2(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [DW-1:0]    div;
    logic             phase;
    logic [5:0]       sec;
    logic [5:0]       min;
    logic [HRS_W-1:0] hrs;
    // Set once time has frozen at the maximum in hold mode; sec then keeps
    // counting internally so min_pulse stays on its one-minute cadence.
    logic             held;

    logic [HRS_W-1:0] ld_hrs;
    logic [5:0]       ld_min;
    logic [5:0]       ld_sec;
    logic             ld_ok;
    logic             tick;
    logic             hrs_at_max;

    assign ld_hrs     = load_hms[HRS_W+11:12];
    assign ld_min     = load_hms[11:6];
    assign ld_sec     = load_hms[5:0];
    assign ld_ok      = (ld_sec <= 6'd59) && (ld_min <= 6'd59) && (32'(ld_hrs) <= HRS_MAX);
    assign tick       = (div == DIV_LAST) && run;
    assign hrs_at_max = (32'(hrs) == HRS_MAX);

    assign HMS_time = {hrs, min, held ? 6'd59 : sec};

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            div            <= '0;
            phase          <= 1'b0;
            sec            <= '0;
            min            <= '0;
            hrs            <= '0;
            held           <= 1'b0;
            sec_accum      <= '0;
            min_accum      <= '0;
            half_sec_pulse <= 1'b0;
            sec_pulse      <= 1'b0;
            min_pulse      <= 1'b0;
            overflow       <= 1'b0;
            load_err       <= 1'b0;
        end else begin
            half_sec_pulse <= 1'b0;
            sec_pulse      <= 1'b0;
            min_pulse      <= 1'b0;
            load_err       <= 1'b0;
            if (load_en) begin
                // A load (accepted or not) swallows any tick in the same cycle.
                if (ld_ok) begin
                    hrs   <= ld_hrs;
                    min   <= ld_min;
                    sec   <= ld_sec;
                    div   <= '0;
                    phase <= 1'b0;
                    held  <= 1'b0;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (tick) begin
                div            <= '0;
                phase          <= ~phase;
                half_sec_pulse <= 1'b1;
                if (phase) begin
                    sec_pulse <= 1'b1;
                    if (sec_accum != '1) sec_accum <= sec_accum + ACC_W'(1);
                    if (sec == 6'd59) begin
                        sec       <= '0;
                        min_pulse <= 1'b1;
                        if (min_accum != '1) min_accum <= min_accum + ACC_W'(1);
                        if (!held) begin
                            if (min != 6'd59) begin
                                min <= min + 6'd1;
                            end else if (!hrs_at_max) begin
                                min <= '0;
                                hrs <= hrs + HRS_W'(1);
                            end else begin
                                overflow <= 1'b1;
                                if (SAT_MODE != 0) begin
                                    held <= 1'b1;
                                end else begin
                                    min <= '0;
                                    hrs <= '0;
                                end
                            end
                        end
                    end else begin
                        sec <= sec + 6'd1;
                    end
                end
            end else if (run) begin
                div <= div + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_timebase_gen.sv
// Bench for timebase_gen: three instances (wrap, hold, 4-bit accumulators) share
// stimulus and are checked every cycle against a seconds-count model.
module tb_timebase_gen;

    localparam int DIV  = 4;
    localparam int TMAX = 99 * 3600 + 59 * 60 + 59;

    logic        clock = 1'b0;
    logic        reset, run, clear, load_en;
    logic [18:0] load_hms;

    logic [18:0] hms0, hms1, hms2;
    logic [12:0] sa0, ma0, sa1, ma1;
    logic [3:0]  sa2, ma2;
    logic        hp0, sp0, mp0, ov0, le0;
    logic        hp1, sp1, mp1, ov1, le1;
    logic        hp2, sp2, mp2, ov2, le2;

    always #5 clock = ~clock;

    timebase_gen #(.DIV(DIV), .SAT_MODE(0)) u0 (
        .clock(clock), .reset(reset), .run(run), .clear(clear), .load_en(load_en),
        .load_hms(load_hms), .HMS_time(hms0), .sec_accum(sa0), .min_accum(ma0),
        .half_sec_pulse(hp0), .sec_pulse(sp0), .min_pulse(mp0), .overflow(ov0), .load_err(le0));
    timebase_gen #(.DIV(DIV), .SAT_MODE(1)) u1 (
        .clock(clock), .reset(reset), .run(run), .clear(clear), .load_en(load_en),
        .load_hms(load_hms), .HMS_time(hms1), .sec_accum(sa1), .min_accum(ma1),
        .half_sec_pulse(hp1), .sec_pulse(sp1), .min_pulse(mp1), .overflow(ov1), .load_err(le1));
    timebase_gen #(.DIV(DIV), .SAT_MODE(0), .ACC_W(4)) u2 (
        .clock(clock), .reset(reset), .run(run), .clear(clear), .load_en(load_en),
        .load_hms(load_hms), .HMS_time(hms2), .sec_accum(sa2), .min_accum(ma2),
        .half_sec_pulse(hp2), .sec_pulse(sp2), .min_pulse(mp2), .overflow(ov2), .load_err(le2));

    logic [49:0] act0, act1, act2;
    assign act0 = {hms0, sa0, ma0, hp0, sp0, mp0, ov0, le0};
    assign act1 = {hms1, sa1, ma1, hp1, sp1, mp1, ov1, le1};
    assign act2 = {hms2, 9'd0, sa2, 9'd0, ma2, hp2, sp2, mp2, ov2, le2};

    // Model state: v is elapsed/loaded time in seconds (may pass TMAX in hold mode).
    typedef struct packed {
        int runcnt;
        int v;
        int sacc;
        int macc;
        bit hp, sp, mp, ovf, lerr;
    } mdl_t;

    mdl_t m0, m1, m2;
    int   compared = 0, mismatched = 0;
    bit   started = 0;
    int   redges = 0, first_sp = 0, hp_cnt = 0, sp_cnt = 0, mp_cnt = 0;

    function automatic mdl_t step(mdl_t m, bit sat, int amax, logic rst, logic clr,
                                  logic ld, logic [18:0] lh, logic rn);
        mdl_t n;
        int h, mi, s;
        n = m;
        n.hp = 0; n.sp = 0; n.mp = 0; n.lerr = 0;
        h  = int'(lh[18:12]);
        mi = int'(lh[11:6]);
        s  = int'(lh[5:0]);
        if (rst || clr) begin
            n = '0;
        end else if (ld) begin
            if (s < 60 && mi < 60 && h <= 99) begin
                n.v = h * 3600 + mi * 60 + s;
                n.runcnt = 0;
            end else begin
                n.lerr = 1;
            end
        end else if (rn) begin
            n.runcnt = n.runcnt + 1;
            if (n.runcnt % DIV == 0) begin
                n.hp = 1;
                if ((n.runcnt / DIV) % 2 == 0) begin
                    n.sp = 1;
                    if (n.sacc < amax) n.sacc = n.sacc + 1;
                    if (n.v == TMAX) n.ovf = 1;
                    n.v = sat ? n.v + 1 : (n.v + 1) % (TMAX + 1);
                    if (n.v % 60 == 0) begin
                        n.mp = 1;
                        if (n.macc < amax) n.macc = n.macc + 1;
                    end
                end
            end
        end
        return n;
    endfunction

    function automatic logic [49:0] expv(mdl_t m, bit sat);
        int d;
        d = (sat && m.v > TMAX) ? TMAX : m.v;
        return {7'(d / 3600), 6'((d / 60) % 60), 6'(d % 60), 13'(m.sacc), 13'(m.macc),
                m.hp, m.sp, m.mp, m.ovf, m.lerr};
    endfunction

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    always @(posedge clock) begin
        m0 <= step(m0, 1'b0, 8191, reset, clear, load_en, load_hms, run);
        m1 <= step(m1, 1'b1, 8191, reset, clear, load_en, load_hms, run);
        m2 <= step(m2, 1'b0, 15,   reset, clear, load_en, load_hms, run);
        if (reset) started <= 1'b1;
        redges <= reset ? 0 : redges + int'(run);
    end

    always @(negedge clock) begin
        if (started) begin
            chk("model_u0", 64'(act0), 64'(expv(m0, 1'b0)));
            chk("model_u1", 64'(act1), 64'(expv(m1, 1'b1)));
            chk("model_u2", 64'(act2), 64'(expv(m2, 1'b0)));
        end
        if (reset) begin
            hp_cnt <= 0; sp_cnt <= 0; mp_cnt <= 0; first_sp <= 0;
        end else begin
            hp_cnt <= hp_cnt + int'(hp0);
            sp_cnt <= sp_cnt + int'(sp0);
            mp_cnt <= mp_cnt + int'(mp0);
            if (sp0 && first_sp == 0) first_sp <= redges;
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1; run = 0; clear = 0; load_en = 0; load_hms = '0;
        cyc(); cyc();
        chk("reset_u0", 64'(act0), 64'd0);
        chk("reset_u2", 64'(act2), 64'd0);

        // Free run for one minute of DIV=4 ticks.
        reset = 0; run = 1;
        repeat (480) cyc();
        @(negedge clock); #1;
        chk("first_sec_pulse_edge", 64'(first_sp), 64'd8);
        chk("half_pulses_480", 64'(hp_cnt), 64'd120);
        chk("sec_pulses_480", 64'(sp_cnt), 64'd60);
        chk("min_pulses_480", 64'(mp_cnt), 64'd1);
        chk("hms_480", 64'(hms0), 64'({7'd0, 6'd1, 6'd0}));
        chk("sec_accum_480", 64'(sa0), 64'd60);
        chk("min_accum_480", 64'(ma0), 64'd1);
        chk("sec_accum_sat4", 64'(sa2), 64'd15);

        // Rollover from 99:59:58.
        load_en = 1; load_hms = {7'd99, 6'd59, 6'd58};
        cyc();
        load_en = 0;
        chk("load_visible", 64'(hms0), 64'({7'd99, 6'd59, 6'd58}));
        repeat (16) cyc();
        chk("wrap_time", 64'(hms0), 64'd0);
        chk("wrap_ovf", 64'(ov0), 64'd1);
        chk("hold_time", 64'(hms1), 64'({7'd99, 6'd59, 6'd59}));
        chk("hold_ovf", 64'(ov1), 64'd1);
        chk("hold_sec_accum", 64'(sa1), 64'd62);
        repeat (1000) cyc();
        chk("wrap_ovf_sticky", 64'(ov0), 64'd1);
        chk("hold_time_later", 64'(hms1), 64'({7'd99, 6'd59, 6'd59}));

        // Rejected loads.
        run = 0; load_en = 1; load_hms = {7'd5, 6'd0, 6'd60};
        cyc();
        chk("rej_sec_err", 64'(le0), 64'd1);
        chk("rej_sec_time", 64'(hms0), 64'({7'd0, 6'd2, 6'd5}));
        load_hms = {7'd100, 6'd0, 6'd0};
        cyc();
        load_en = 0;
        chk("rej_hrs_err", 64'(le0), 64'd1);
        chk("rej_hrs_time", 64'(hms1), 64'({7'd99, 6'd59, 6'd59}));
        cyc();
        chk("err_one_cycle", 64'(le0), 64'd0);

        // Clear, then a load that lands on a tick cycle.
        clear = 1;
        cyc();
        clear = 0;
        chk("clear_u0", 64'(act0), 64'd0);
        chk("clear_u1", 64'(act1), 64'd0);
        run = 1;
        repeat (3) cyc();
        load_en = 1; load_hms = {7'd1, 6'd2, 6'd3};
        cyc();
        load_en = 0;
        chk("load_on_tick_time", 64'(hms0), 64'({7'd1, 6'd2, 6'd3}));
        chk("load_on_tick_nopulse", 64'(hp0), 64'd0);
        repeat (4) cyc();
        chk("tick_after_load", 64'(hp0), 64'd1);

        // Randomized traffic with near-maximum preloads.
        repeat (3000) begin
            run     = ($urandom_range(0, 9) < 8);
            clear   = ($urandom_range(0, 299) == 0);
            reset   = ($urandom_range(0, 999) == 0);
            load_en = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 1) == 0)
                load_hms = {7'($urandom_range(95, 101)), 6'($urandom_range(56, 61)),
                            6'($urandom_range(54, 61))};
            else
                load_hms = 19'($urandom);
            cyc();
        end

        // Reset beats clear and an invalid load.
        reset = 1; clear = 1; load_en = 1; run = 1; load_hms = {7'd120, 6'd63, 6'd63};
        cyc();
        chk("reset_prio_u0", 64'(act0), 64'd0);
        chk("reset_prio_u1", 64'(act1), 64'd0);
        reset = 0; clear = 0; load_en = 0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
